e203_exu_fpu_fmis_wbck: RTL

- Writeback buffer directly downstream of the FPU misc move stage.
- Accepts the move result plus its destination tag, holds it in a small in-order FIFO, and presents it to the FPU/integer writeback arbiter through a valid/ready handshake.
- Registered outputs cut the combinational valid/ready/data path from the misc unit to the writeback arbiter.
- Supports a synchronous flush for pipeline kill.

---
 rtl/e203_exu_fpu_fmis_wbck.sv | 69 ++++++
 1 files changed

// File: rtl/e203_exu_fpu_fmis_wbck.sv
// Writeback buffer between the FPU misc move stage and the writeback arbiter.
// In-order FIFO with wrap-bit pointers; outputs come straight from storage registers.
module e203_exu_fpu_fmis_wbck #(
  parameter int DEPTH  = 2,
  parameter int ITAG_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fmis_wbck_i_valid,
  output logic                     fmis_wbck_i_ready,
  input  logic [31:0]              fmis_wbck_i_wdat,
  input  logic [4:0]               fmis_wbck_i_rdidx,
  input  logic                     fmis_wbck_i_rdfpu,
  input  logic [ITAG_W-1:0]        fmis_wbck_i_itag,
  output logic                     fmis_wbck_o_valid,
  input  logic                     fmis_wbck_o_ready,
  output logic [31:0]              fmis_wbck_o_wdat,
  output logic [4:0]               fmis_wbck_o_rdidx,
  output logic                     fmis_wbck_o_rdfpu,
  output logic [ITAG_W-1:0]        fmis_wbck_o_itag,
  input  logic                     fmis_wbck_flush,
  output logic [$clog2(DEPTH):0]   fmis_wbck_cnt,
  output logic                     fmis_wbck_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 32 + 5 + 1 + ITAG_W;

  logic [DEPTH-1:0][EW-1:0] mem;
  logic [PW:0]              wptr;
  logic [PW:0]              rptr;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;

  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
    // Ready ignores o_ready so a full buffer never chains pop into push.
    fmis_wbck_i_ready = !full && !fmis_wbck_flush;
    fmis_wbck_o_valid = !empty;
    push = fmis_wbck_i_valid && fmis_wbck_i_ready;
    pop  = fmis_wbck_o_valid && fmis_wbck_o_ready;
    {fmis_wbck_o_wdat, fmis_wbck_o_rdidx, fmis_wbck_o_rdfpu, fmis_wbck_o_itag} = mem[rptr[PW-1:0]];
    fmis_wbck_cnt   = wptr - rptr;
    fmis_wbck_empty = empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '0;
    end else if (fmis_wbck_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[PW-1:0]] <= {fmis_wbck_i_wdat, fmis_wbck_i_rdidx, fmis_wbck_i_rdfpu, fmis_wbck_i_itag};
        wptr <= wptr + (PW+1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (PW+1)'(1);
      end
    end
  end

endmodule
